// File: rtl/iir_out_decim.sv
// Output stage for the IIR cascade: drops the first SKIP samples and averages blocks of 2**LOG2_DEC samples.
// Each average is rounded and saturated, then queued in a DEPTH-entry FIFO behind a valid/ready stream.
module iir_out_decim #(
    parameter int IN_W     = 11,
    parameter int OUT_W    = 11,
    parameter int LOG2_DEC = 2,
    parameter int DEPTH    = 8,
    parameter int SKIP     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IN_W-1:0]            z_in,
    input  logic                       en,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int ACC_W = IN_W + LOG2_DEC;
    localparam int PH_W  = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam int SK_W  = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = AW + 1;
    localparam int RND   = (2 ** LOG2_DEC) / 2;

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic {S_FLUSH, S_ACC} state_t;
    localparam state_t RST_STATE = (SKIP == 0) ? S_ACC : S_FLUSH;

    state_t                    state_q, state_d;
    logic [SK_W-1:0]           skip_q, skip_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic                      ovf_q, ovf_d;
    logic [OUT_W-1:0]          mem [DEPTH];

    logic signed [ACC_W-1:0]   z_ext, sum;
    logic signed [ACC_W:0]     rnd_sum, avg;
    logic [OUT_W-1:0]          res;
    logic                      push, pop, full, wr_en, drop;

    // Block sum of D samples fits in ACC_W bits; one extra bit absorbs the rounding offset.
    assign z_ext   = ACC_W'($signed(z_in));
    assign sum     = acc_q + z_ext;
    assign rnd_sum = (ACC_W+1)'(sum) + (ACC_W+1)'(RND);
    assign avg     = rnd_sum >>> LOG2_DEC;
    assign res     = (avg > SAT_HI) ? SAT_HI[OUT_W-1:0] :
                     (avg < SAT_LO) ? SAT_LO[OUT_W-1:0] : avg[OUT_W-1:0];

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (en) begin
            case (state_q)
                S_FLUSH: begin
                    if (skip_q == SK_W'(SKIP - 1)) begin
                        state_d = S_ACC;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
                S_ACC: begin
                    if (phase_q == PH_W'(2 ** LOG2_DEC - 1)) begin
                        push    = 1'b1;
                        acc_d   = '0;
                        phase_d = '0;
                    end else begin
                        acc_d   = sum;
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop      = (fill_q != '0) && m_ready;
        full     = (fill_q == FW'(DEPTH));
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        fill_d   = fill_q + FW'(wr_en) - FW'(pop);
        ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            skip_q   <= '0;
            phase_q  <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; it is never read while fill is zero, so contents are don't-care.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= res;
        end
    end

    assign m_valid = (fill_q != '0);
    assign m_data  = m_valid ? mem[rd_ptr_q] : '0;
    assign fill    = fill_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_iir_out_decim.sv
// Directed bench for iir_out_decim: flush latency, rounding, saturation, FIFO full/overflow, en gaps and reset.
// A second instance with OUT_W=8 shares the stimulus and is checked only for saturation.
module tb_iir_out_decim;

    localparam int IN_W = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic [IN_W-1:0]    z_in;
    logic               en;
    logic               m_ready;
    logic               ovf_clr;
    logic [10:0]        m_data;
    logic               m_valid;
    logic [3:0]         fill;
    logic               ovf;
    logic [7:0]         m_data8;
    logic               m_valid8;
    logic [3:0]         fill8;
    logic               ovf8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iir_out_decim dut (
        .clk(clk), .rst(rst), .z_in(z_in), .en(en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fill(fill), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    iir_out_decim #(.OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .z_in(z_in), .en(en),
        .m_data(m_data8), .m_valid(m_valid8), .m_ready(m_ready),
        .fill(fill8), .ovf(ovf8), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are read at the same point.
    task automatic tick(input logic e, input int z);
        en   = e;
        z_in = IN_W'(z);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sd(input logic [10:0] d);
        return 32'($signed(d));
    endfunction

    // One block with m_ready=1 on an empty FIFO: result visible right after the 4th sample.
    task automatic block(input string tag, input int a, input int b, input int c, input int d,
                         input int exp);
        tick(1'b1, a);
        tick(1'b1, b);
        tick(1'b1, c);
        check({tag, "_pre"}, 32'(m_valid), 0);
        tick(1'b1, d);
        check({tag, "_valid"}, 32'(m_valid), 1);
        check({tag, "_data"}, sd(m_data), exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; z_in = '0; m_ready = 1'b0; ovf_clr = 1'b0;
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_fill", 32'(fill), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_data", sd(m_data), 0);

        // T1: 4 flushed + 4 accumulated samples, result on the 8th post-reset edge.
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 100);
            check($sformatf("t1_first_valid_%0d", i), 32'(m_valid), (i == 8) ? 1 : 0);
        end
        check("t1_first_data", sd(m_data), 100);
        for (int b = 0; b < 3; b++) begin
            for (int j = 1; j <= 4; j++) begin
                tick(1'b1, 100);
                check($sformatf("t1_valid_b%0d_%0d", b, j), 32'(m_valid), (j == 4) ? 1 : 0);
            end
            check($sformatf("t1_data_b%0d", b), sd(m_data), 100);
        end

        // T2: rounding half toward +inf.
        block("t2_a", 1, 1, 1, 0, 1);
        block("t2_b", -1, -1, -1, -2, -1);
        block("t2_c", 2, 2, 1, 1, 2);
        block("t2_half_pos", 1, 1, 0, 0, 1);
        block("t2_half_neg", -1, -1, 0, 0, 0);
        block("t2_neg_half2", -2, -2, -2, -2, -2);

        // T3: saturation on the OUT_W=8 instance; the full-width instance passes through.
        block("t3_pos", 1023, 1023, 1023, 1023, 1023);
        check("t3_pos_sat8", 32'($signed(m_data8)), 127);
        block("t3_neg", -1024, -1024, -1024, -1024, -1024);
        check("t3_neg_sat8", 32'($signed(m_data8)), -128);
        tick(1'b0, 0);
        check("t3_drained", 32'(fill), 0);

        // T4: fill the FIFO, drop the 9th result (with ovf_clr asserted: set wins).
        m_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            ovf_clr = (k == 9);
            for (int j = 0; j < 4; j++) tick(1'b1, k);
            ovf_clr = 1'b0;
            check($sformatf("t4_fill_%0d", k), 32'(fill), (k < 9) ? k : 8);
            check($sformatf("t4_ovf_%0d", k), 32'(ovf), (k == 9) ? 1 : 0);
        end
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t4_drain_valid_%0d", k), 32'(m_valid), 1);
            check($sformatf("t4_drain_data_%0d", k), sd(m_data), k);
            tick(1'b0, 0);
            check($sformatf("t4_drain_fill_%0d", k), 32'(fill), 8 - k);
        end
        check("t4_empty_valid", 32'(m_valid), 0);
        tick(1'b0, 0);
        check("t4_empty_ready_fill", 32'(fill), 0);
        check("t4_ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick(1'b0, 0);
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", 32'(ovf), 0);

        // T5: push and pop on the same edge while full.
        m_ready = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            for (int j = 0; j < 4; j++) tick(1'b1, k);
        end
        check("t5_full", 32'(fill), 8);
        for (int j = 0; j < 3; j++) tick(1'b1, 19);
        m_ready = 1'b1;
        tick(1'b1, 19);
        check("t5_fill_stays", 32'(fill), 8);
        check("t5_no_ovf", 32'(ovf), 0);
        for (int k = 12; k <= 19; k++) begin
            check($sformatf("t5_order_%0d", k), sd(m_data), k);
            tick(1'b0, 0);
        end
        check("t5_drained", 32'(fill), 0);

        // T6: en gaps stretch each block to 8 cycles.
        for (int t = 0; t < 16; t++) begin
            tick((t % 2) == 0, 40);
            check($sformatf("t6_gap_valid_%0d", t), 32'(m_valid), (t == 6 || t == 14) ? 1 : 0);
            if (t == 6 || t == 14) check($sformatf("t6_gap_data_%0d", t), sd(m_data), 40);
        end
        m_ready = 1'b0;
        for (int t = 0; t < 16; t++) tick((t % 2) == 0, 40);
        tick(1'b1, 40);
        tick(1'b1, 40);
        check("t6_pre_rst_fill", 32'(fill), 2);
        rst = 1'b1;
        tick(1'b0, 0);
        check("t6_rst_valid", 32'(m_valid), 0);
        check("t6_rst_fill", 32'(fill), 0);
        check("t6_rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, -7);
            check($sformatf("t6_reflush_valid_%0d", i), 32'(m_valid), (i == 8) ? 1 : 0);
        end
        check("t6_reflush_data", sd(m_data), -7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
